// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the muldiv sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 16;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULH = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_REM  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq_sign_mag.sv
// Conditional two's-complement negation, used for operand
// magnitudes and for result sign fix-up.
module sign_mag #(
    parameter int N = 16
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply/divide sequencer (shift-add / restoring).
// Define MULDIV_UNSIGNED_EN to add the uns port for unsigned variants.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             uns,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [1:0]         op_q;
    logic               sg_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   ma_q, mb_q;
    logic               sa_q, sb_q;
    logic               dz_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic               busy_q, done_q, dzo_q;
    logic [WIDTH-1:0]   result_q;

    logic               sg_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum_d;
    logic [WIDTH:0]     trial_d;
    logic               ge_d;
    logic [WIDTH-1:0]   rem_d;
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic               fix_neg;

`ifdef MULDIV_UNSIGNED_EN
    assign sg_in = ~uns;
`else
    assign sg_in = 1'b1;
`endif

    sign_mag #(.N(WIDTH)) u_mag_a (
        .val_i (a_q),
        .neg_i (a_q[WIDTH-1] & sg_q),
        .res_o (mag_a)
    );

    sign_mag #(.N(WIDTH)) u_mag_b (
        .val_i (b_q),
        .neg_i (b_q[WIDTH-1] & sg_q),
        .res_o (mag_b)
    );

    sign_mag #(.N(2*WIDTH)) u_fix (
        .val_i (fix_in),
        .neg_i (fix_neg),
        .res_o (fix_out)
    );

    // Multiply step: add |a| into the upper half, carry lands in the shift.
    assign msum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? ma_q : '0)};
    assign trial_d = {rem_q, acc_q[WIDTH-1]};
    assign ge_d    = trial_d >= {1'b0, mb_q};
    assign rem_d   = ge_d ? WIDTH'(trial_d - {1'b0, mb_q})
                          : trial_d[WIDTH-1:0];

    always_comb begin
        fix_in  = acc_q;
        fix_neg = sa_q ^ sb_q;
        case (op_q)
            MD_DIV: fix_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
            MD_REM: begin
                fix_in  = {{WIDTH{1'b0}}, rem_q};
                fix_neg = sa_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MUL;
            sg_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        sg_q    <= sg_in;
                        dz_q    <= 1'b0;
                        dzo_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    sa_q  <= a_q[WIDTH-1] & sg_q;
                    sb_q  <= b_q[WIDTH-1] & sg_q;
                    ma_q  <= mag_a;
                    mb_q  <= mag_b;
                    acc_q <= {{WIDTH{1'b0}}, (op_q[1] ? mag_a : mag_b)};
                    rem_q <= '0;
                    cnt_q <= CW'(WIDTH);
                    if (op_q[1] && b_q == '0) begin
                        dz_q    <= 1'b1;
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q[1]) begin
                        rem_q <= rem_d;
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH],
                                  acc_q[WIDTH-2:0], ge_d};
                    end else begin
                        acc_q <= {msum_d, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (dz_q)
                        result_q <= (op_q == MD_DIV) ? '1 : a_q;
                    else if (op_q == MD_MULH)
                        result_q <= fix_out[2*WIDTH-1:WIDTH];
                    else
                        result_q <= fix_out[WIDTH-1:0];
                    dzo_q   <= dz_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, dz;
    logic [15:0] result;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
`ifdef MULDIV_UNSIGNED_EN
        .uns         (1'b0),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (dz)
    );

    // Issue one op, scramble operands after acceptance, wait for done.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, output logic [15:0] r,
                         output logic z, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = y ^ 16'h5A5A; op = ~o;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        r = result;
        z = dz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL reset_done got=%b want=0", done); end
        n_chk++; if (result !== 16'h0) begin n_fail++;
            $display("FAIL reset_result got=%h want=0000", result); end
        n_chk++; if (dz !== 1'b0) begin n_fail++;
            $display("FAIL reset_dz got=%b want=0", dz); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [15:0] r; logic z; int lat;
        do_op(MD_MUL, 16'hFFFD, 16'h0007, r, z, lat);
        n_chk++; if (lat != 18) begin n_fail++;
            $display("FAIL mul_latency got=%0d want=18", lat); end
        n_chk++; if (r !== 16'hFFEB) begin n_fail++;
            $display("FAIL mul_neg got=%h want=FFEB", r); end
        do_op(MD_MULH, 16'hFFFD, 16'h0007, r, z, lat);
        n_chk++; if (r !== 16'hFFFF) begin n_fail++;
            $display("FAIL mulh_neg got=%h want=FFFF", r); end
        do_op(MD_MULH, 16'h7FFF, 16'h7FFF, r, z, lat);
        n_chk++; if (r !== 16'h3FFF) begin n_fail++;
            $display("FAIL mulh_max got=%h want=3FFF", r); end
        do_op(MD_MUL, 16'h7FFF, 16'h7FFF, r, z, lat);
        n_chk++; if (r !== 16'h0001) begin n_fail++;
            $display("FAIL mul_max got=%h want=0001", r); end
    endtask

    task automatic test_div();
        logic [15:0] r; logic z; int lat;
        do_op(MD_DIV, 16'hFFF9, 16'h0002, r, z, lat);
        n_chk++; if (r !== 16'hFFFD) begin n_fail++;
            $display("FAIL div_neg got=%h want=FFFD", r); end
        n_chk++; if (z !== 1'b0) begin n_fail++;
            $display("FAIL div_neg_dz got=%b want=0", z); end
        n_chk++; if (lat != 18) begin n_fail++;
            $display("FAIL div_latency got=%0d want=18", lat); end
        do_op(MD_REM, 16'hFFF9, 16'h0002, r, z, lat);
        n_chk++; if (r !== 16'hFFFF) begin n_fail++;
            $display("FAIL rem_neg got=%h want=FFFF", r); end
    endtask

    task automatic test_div_zero();
        logic [15:0] r; logic z; int lat;
        do_op(MD_DIV, 16'h0005, 16'h0000, r, z, lat);
        n_chk++; if (lat != 2) begin n_fail++;
            $display("FAIL dz_latency got=%0d want=2", lat); end
        n_chk++; if (r !== 16'hFFFF) begin n_fail++;
            $display("FAIL dz_div got=%h want=FFFF", r); end
        n_chk++; if (z !== 1'b1) begin n_fail++;
            $display("FAIL dz_div_flag got=%b want=1", z); end
        do_op(MD_REM, 16'h0005, 16'h0000, r, z, lat);
        n_chk++; if (r !== 16'h0005) begin n_fail++;
            $display("FAIL dz_rem got=%h want=0005", r); end
        n_chk++; if (z !== 1'b1) begin n_fail++;
            $display("FAIL dz_rem_flag got=%b want=1", z); end
    endtask

    task automatic test_overflow();
        logic [15:0] r; logic z; int lat;
        do_op(MD_DIV, 16'h8000, 16'hFFFF, r, z, lat);
        n_chk++; if (r !== 16'h8000) begin n_fail++;
            $display("FAIL ovf_div got=%h want=8000", r); end
        n_chk++; if (z !== 1'b0) begin n_fail++;
            $display("FAIL ovf_dz got=%b want=0", z); end
        do_op(MD_REM, 16'h8000, 16'hFFFF, r, z, lat);
        n_chk++; if (r !== 16'h0000) begin n_fail++;
            $display("FAIL ovf_rem got=%h want=0000", r); end
    endtask

    task automatic test_done_pulse();
        logic [15:0] r; logic z; int lat;
        do_op(MD_MUL, 16'h0009, 16'hFFFE, r, z, lat);
        n_chk++; if (r !== 16'hFFEE) begin n_fail++;
            $display("FAIL pulse_result got=%h want=FFEE", r); end
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL pulse_width got=%b want=0", done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL pulse_idle_busy got=%b want=0", busy); end
        n_chk++; if (result !== 16'hFFEE) begin n_fail++;
            $display("FAIL pulse_hold got=%h want=FFEE", result); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic z; int lat;
        do_op(MD_MUL, 16'h0004, 16'h0005, r, z, lat);
        n_chk++; if (r !== 16'h0014) begin n_fail++;
            $display("FAIL b2b_first got=%h want=0014", r); end
        do_op(MD_MUL, 16'h0002, 16'h0003, r, z, lat);
        n_chk++; if (lat != 18) begin n_fail++;
            $display("FAIL b2b_latency got=%0d want=18", lat); end
        n_chk++; if (r !== 16'h0006) begin n_fail++;
            $display("FAIL b2b_result got=%h want=0006", r); end
    endtask

    task automatic test_ignore_start();
        int lat;
        lat = -1;
        @(negedge clk);
        op = MD_MUL; a = 16'h0002; b = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 3 && i <= 6) begin
                op = MD_DIV; a = 16'h0064; b = 16'h0007; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (i == 4) begin
                n_chk++; if (busy !== 1'b1) begin n_fail++;
                    $display("FAIL ign_busy got=%b want=1", busy); end
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        n_chk++; if (lat != 18) begin n_fail++;
            $display("FAIL ign_latency got=%0d want=18", lat); end
        n_chk++; if (result !== 16'h0006) begin n_fail++;
            $display("FAIL ign_result got=%h want=0006", result); end
    endtask

    task automatic test_mid_reset();
        int seen;
        seen = 0;
        @(negedge clk);
        op = MD_DIV; a = 16'h1234; b = 16'h0007; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL mrst_pre_busy got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL mrst_busy got=%b want=0", busy); end
        n_chk++; if (result !== 16'h0000) begin n_fail++;
            $display("FAIL mrst_result got=%h want=0000", result); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_chk++; if (seen != 0) begin n_fail++;
            $display("FAIL mrst_no_done got=%0d want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_done_pulse();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
